// File: rtl/umul_rr_sched_pkg.sv
// Shared types and width helpers for the round-robin multiplier scheduler.
package umul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      RESP = 2'd2
   } state_t;

   localparam int unsigned N_DEF = 64;

   function automatic int unsigned id_width(input int unsigned nreq);
      return (nreq < 2) ? 1 : $clog2(nreq);
   endfunction

   function automatic int unsigned cnt_width(input int unsigned n);
      return $clog2(n + 8);
   endfunction

   // Cycle count in BUSY at which the multiplier is considered hung.
   function automatic int unsigned wd_limit(input int unsigned n);
      return n + 4;
   endfunction

endpackage

// File: rtl/umul_rr_sched_if.sv
// Requester and response handshake bundle for the multiplier scheduler.
interface umul_rr_sched_if
   import umul_pkg::*;
#(
   parameter int unsigned N    = N_DEF,
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = id_width(NREQ)
) ();

   logic [NREQ-1:0]   req_valid;
   logic [NREQ-1:0]   req_ready;
   logic [NREQ*N-1:0] req_a;
   logic [NREQ*N-1:0] req_b;
   logic              rsp_valid;
   logic              rsp_ready;
   logic [IDW-1:0]    rsp_id;
   logic [2*N-1:0]    rsp_res;

   modport master (
      output req_valid, req_a, req_b, rsp_ready,
      input  req_ready, rsp_valid, rsp_id, rsp_res
   );

   modport slave (
      input  req_valid, req_a, req_b, rsp_ready,
      output req_ready, rsp_valid, rsp_id, rsp_res
   );

endinterface

// File: rtl/umul_rr_sched_arb.sv
// Round-robin pick: first valid requester at or after the pointer, wrapping.
module umul_rr_arb #(
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = 2
) (
   input  logic [NREQ-1:0] req,
   input  logic [IDW-1:0]  ptr,
   output logic [NREQ-1:0] grant_c,
   output logic [IDW-1:0]  idx_c,
   output logic            any_c
);

   always_comb begin
      int unsigned s;
      grant_c = '0;
      idx_c   = '0;
      any_c   = 1'b0;
      s       = 0;
      for (int unsigned k = 0; k < NREQ; k++) begin
         s = 32'(ptr) + k;
         if (s >= NREQ) s = s - NREQ;
         for (int unsigned j = 0; j < NREQ; j++) begin
            if (!any_c && (s == j) && req[j]) begin
               grant_c[j] = 1'b1;
               idx_c      = IDW'(j);
               any_c      = 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/umul_rr_sched.sv
// Shares one iterative multiplier among NREQ requesters, one op in flight,
// returning the full product tagged with the owner id.
module umul_rr_sched
   import umul_pkg::*;
#(
   parameter int unsigned N    = N_DEF,
   parameter int unsigned NREQ = 4,
   parameter int unsigned IDW  = id_width(NREQ),
   parameter int unsigned CW   = cnt_width(N)
) (
   input  logic           clk,
   input  logic           rst,
   umul_rr_sched_if.slave bus,
   output logic           mul_strt,
   output logic [N-1:0]   mul_a,
   output logic [N-1:0]   mul_b,
   input  logic [2*N-1:0] mul_res,
   input  logic           mul_done,
   output logic           busy,
   output logic [CW-1:0]  last_cycles,
   output logic           err
);

   localparam logic [CW-1:0]  WD_CNT  = CW'(wd_limit(N));
   localparam logic [CW-1:0]  CNT_MAX = '1;
   localparam logic [IDW-1:0] LAST_ID = IDW'(NREQ - 1);

   state_t         state, state_n;
   logic [IDW-1:0] rr_ptr, id_q;
   logic [CW-1:0]  cnt;
   logic [NREQ-1:0] grant_c;
   logic [IDW-1:0] gidx_c;
   logic           any_c;
   logic           take_req, take_done, take_rsp;
   logic [N-1:0]   sel_a, sel_b;

   umul_rr_arb #(.NREQ(NREQ), .IDW(IDW)) u_arb (
      .req     (bus.req_valid),
      .ptr     (rr_ptr),
      .grant_c (grant_c),
      .idx_c   (gidx_c),
      .any_c   (any_c)
   );

   // Operand mux for the granted requester.
   always_comb begin
      sel_a = '0;
      sel_b = '0;
      for (int unsigned i = 0; i < NREQ; i++) begin
         if (gidx_c == IDW'(i)) begin
            sel_a = bus.req_a[i*N +: N];
            sel_b = bus.req_b[i*N +: N];
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_n;
   end

   // Done is only trusted once strt has dropped; before that it belongs to the previous op.
   always_comb begin
      state_n       = state;
      take_req      = 1'b0;
      take_done     = 1'b0;
      take_rsp      = 1'b0;
      bus.req_ready = '0;
      unique case (state)
         IDLE: if (any_c) begin
            bus.req_ready = grant_c;
            take_req      = 1'b1;
            state_n       = BUSY;
         end
         BUSY: if (mul_done && !mul_strt) begin
            take_done = 1'b1;
            state_n   = RESP;
         end
         RESP: if (bus.rsp_ready) begin
            take_rsp = 1'b1;
            state_n  = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         mul_strt      <= 1'b0;
         mul_a         <= '0;
         mul_b         <= '0;
         id_q          <= '0;
         rr_ptr        <= '0;
         cnt           <= '0;
         busy          <= 1'b0;
         err           <= 1'b0;
         last_cycles   <= '0;
         bus.rsp_valid <= 1'b0;
         bus.rsp_id    <= '0;
         bus.rsp_res   <= '0;
      end else begin
         mul_strt <= take_req;
         busy     <= (state_n != IDLE);
         if (take_req) begin
            mul_a <= sel_a;
            mul_b <= sel_b;
            id_q  <= gidx_c;
            cnt   <= '0;
         end else if (state == BUSY && cnt != CNT_MAX) begin
            cnt <= cnt + 1'b1;
         end
         if (state == BUSY && cnt >= WD_CNT) err <= 1'b1;
         if (take_done) begin
            bus.rsp_res   <= mul_res;
            bus.rsp_id    <= id_q;
            last_cycles   <= cnt;
            bus.rsp_valid <= 1'b1;
         end
         if (take_rsp) begin
            bus.rsp_valid <= 1'b0;
            rr_ptr        <= (id_q == LAST_ID) ? '0 : id_q + 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_umul_rr_sched.sv
// Bench for umul_rr_sched paired with a behavioural iterative shift-add multiplier.
module tb_umul_rr_sched;

   localparam int unsigned N    = 64;
   localparam int unsigned NREQ = 4;

   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   umul_rr_sched_if #(.N(N), .NREQ(NREQ)) bus ();

   logic           mul_strt, mul_done, busy, err;
   logic [N-1:0]   mul_a, mul_b;
   logic [2*N-1:0] mul_res;
   logic [6:0]     last_cycles;

   umul_rr_sched #(.N(N), .NREQ(NREQ)) dut (
      .clk         (clk),
      .rst         (rst),
      .bus         (bus),
      .mul_strt    (mul_strt),
      .mul_a       (mul_a),
      .mul_b       (mul_b),
      .mul_res     (mul_res),
      .mul_done    (mul_done),
      .busy        (busy),
      .last_cycles (last_cycles),
      .err         (err)
   );

   // Shift-add multiplier: N iterations after strt, done held until next strt.
   logic [2*N-1:0] m_ma, m_acc;
   logic [N-1:0]   m_mb;
   logic [6:0]     m_iter;
   logic           m_done, stall_mul;
   assign mul_res  = m_acc;
   assign mul_done = m_done;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_ma <= '0; m_mb <= '0; m_acc <= '0; m_iter <= '0; m_done <= 1'b0;
      end else if (mul_strt) begin
         m_ma <= {64'd0, mul_a}; m_mb <= mul_b; m_acc <= '0;
         m_iter <= 7'(N); m_done <= 1'b0;
      end else if (m_iter != 0 && !stall_mul) begin
         if (m_mb[0]) m_acc <= m_acc + m_ma;
         m_ma   <= m_ma << 1;
         m_mb   <= m_mb >> 1;
         m_iter <= m_iter - 7'd1;
         if (m_iter == 7'd1) m_done <= 1'b1;
      end
   end

   typedef struct {
      int           id;
      logic [127:0] res;
   } sb_t;

   typedef struct {
      int           id;
      logic [63:0]  a;
      logic [63:0]  b;
      logic [127:0] exp;
   } vec_t;

   sb_t          sb[$];
   int           resp_log[$];
   logic [127:0] expv[NREQ];
   int           gcnt[NREQ];
   int           hold_cnt[NREQ];
   int           tests = 0;
   int           fails = 0;

   task automatic check(input string nm, input logic [127:0] act, input logic [127:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // Grant monitor: record the accepted pair, then release valid unless a hold is armed.
   always @(negedge clk) begin
      if (!rst && bus.req_ready != '0) begin
         int g;
         g = -1;
         check("ready_onehot", 128'($onehot(bus.req_ready)), 128'd1);
         for (int i = 0; i < NREQ; i++) begin
            if (bus.req_ready[i] && bus.req_valid[i]) begin
               sb.push_back('{i, expv[i]});
               gcnt[i]++;
               g = i;
            end
         end
         if (g >= 0) begin
            @(posedge clk);
            #1;
            if (hold_cnt[g] > 0) hold_cnt[g]--;
            else bus.req_valid[g] = 1'b0;
         end
      end
   end

   // Response monitor: pop the scoreboard on every rsp handshake.
   always @(negedge clk) begin
      if (!rst && bus.rsp_valid && bus.rsp_ready) begin
         if (sb.size() == 0) begin
            check("rsp_unexpected", 128'd1, 128'd0);
         end else begin
            sb_t e;
            e = sb.pop_front();
            check("rsp_id", 128'(bus.rsp_id), 128'(e.id));
            check("rsp_res", bus.rsp_res, e.res);
         end
         resp_log.push_back(int'(bus.rsp_id));
      end
   end

   task automatic issue(input int id, input logic [63:0] a, input logic [63:0] b,
                        input logic [127:0] exp);
      bus.req_a[id*64 +: 64] = a;
      bus.req_b[id*64 +: 64] = b;
      expv[id]               = exp;
      bus.req_valid[id]      = 1'b1;
   endtask

   task automatic wait_resps(input int target);
      int budget;
      budget = 3000;
      while (resp_log.size() < target && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #1;
      if (resp_log.size() < target) check("resp_timeout", 128'(resp_log.size()), 128'(target));
   endtask

   task automatic check_order(input int base, input int n, input int e0, input int e1,
                              input int e2, input int e3);
      int e[4];
      e = '{e0, e1, e2, e3};
      for (int k = 0; k < n; k++) begin
         if (base + k < resp_log.size()) check("order", 128'(resp_log[base+k]), 128'(e[k]));
         else check("order_missing", 128'd0, 128'd1);
      end
   endtask

   initial begin
      vec_t         tbl[6];
      int           base, g0, budget;
      logic         stable;
      logic [127:0] r_res;
      logic [1:0]   r_id;

      tbl[0] = '{0, 64'd3, 64'd5, 128'd15};
      tbl[1] = '{2, 64'd7, 64'd0, 128'd0};
      tbl[2] = '{1, 64'd1234, 64'd5678, 128'd7006652};
      tbl[3] = '{2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 128'h1_FFFF_FFFF_FFFF_FFFE};
      tbl[4] = '{1, 64'h1_0000_0000, 64'h1_0000_0000, 128'h1_0000_0000_0000_0000};
      tbl[5] = '{3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF,
                 128'hFFFF_FFFF_FFFF_FFFE_0000_0000_0000_0001};

      rst = 1'b1; stall_mul = 1'b0;
      bus.req_valid = '0; bus.req_a = '0; bus.req_b = '0; bus.rsp_ready = 1'b1;
      for (int i = 0; i < NREQ; i++) begin
         gcnt[i] = 0; hold_cnt[i] = 0; expv[i] = '0;
      end
      repeat (3) @(posedge clk);
      #1;
      check("rst_busy", 128'(busy), 128'd0);
      check("rst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
      check("rst_req_ready", 128'(bus.req_ready), 128'd0);
      check("rst_mul_strt", 128'(mul_strt), 128'd0);
      check("rst_err", 128'(err), 128'd0);
      check("rst_last_cycles", 128'(last_cycles), 128'd0);
      check("rst_rsp_res", bus.rsp_res, 128'd0);
      rst = 1'b0;
      @(posedge clk); #1;

      // Single transactions, one per table row.
      for (int k = 0; k < 6; k++) begin
         base = resp_log.size();
         g0   = gcnt[tbl[k].id];
         issue(tbl[k].id, tbl[k].a, tbl[k].b, tbl[k].exp);
         wait_resps(base + 1);
         check_order(base, 1, tbl[k].id, 0, 0, 0);
         check("grant_pulses", 128'(gcnt[tbl[k].id]), 128'(g0 + 1));
         check("err_clear", 128'(err), 128'd0);
         check("latency_le65", 128'(last_cycles <= 7'd65 && last_cycles >= 7'd1), 128'd1);
      end

      // All four at once, then a sparse pair.
      base = resp_log.size();
      for (int i = 0; i < 4; i++) issue(i, 64'(i), 64'(i + 1), 128'(i * (i + 1)));
      wait_resps(base + 4);
      check_order(base, 4, 0, 1, 2, 3);
      base = resp_log.size();
      issue(1, 64'd10, 64'd11, 128'd110);
      issue(3, 64'd12, 64'd13, 128'd156);
      wait_resps(base + 2);
      check_order(base, 2, 1, 3, 0, 0);

      // Consumer back-pressure with another requester waiting.
      base = resp_log.size();
      bus.rsp_ready = 1'b0;
      issue(0, 64'd9, 64'd9, 128'd81);
      issue(2, 64'd4, 64'd4, 128'd16);
      budget = 300;
      while (!bus.rsp_valid && budget > 0) begin
         @(negedge clk);
         budget--;
      end
      check("stall_rsp_valid", 128'(bus.rsp_valid), 128'd1);
      r_res = bus.rsp_res; r_id = bus.rsp_id;
      check("stall_rsp_id", 128'(r_id), 128'd0);
      check("stall_rsp_res", r_res, 128'd81);
      stable = 1'b1;
      repeat (10) begin
         @(negedge clk);
         if (!bus.rsp_valid || bus.rsp_res !== r_res || bus.rsp_id !== r_id || bus.req_ready != '0)
            stable = 1'b0;
      end
      check("stall_stable", 128'(stable), 128'd1);
      @(posedge clk); #1;
      bus.rsp_ready = 1'b1;
      wait_resps(base + 2);
      check_order(base, 2, 0, 2, 0, 0);

      // Held valid on 1 must yield to 2 before its second grant.
      base = resp_log.size();
      hold_cnt[1] = 1;
      issue(0, 64'd2, 64'd3, 128'd6);
      issue(1, 64'd5, 64'd5, 128'd25);
      issue(2, 64'd8, 64'd8, 128'd64);
      wait_resps(base + 4);
      check_order(base, 4, 0, 1, 2, 1);

      // A request withdrawn while busy is never granted.
      base = resp_log.size();
      g0   = gcnt[0];
      issue(3, 64'd5, 64'd5, 128'd25);
      budget = 50;
      while (!busy && budget > 0) begin
         @(posedge clk);
         budget--;
      end
      #1;
      bus.req_valid[0] = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      bus.req_valid[0] = 1'b0;
      wait_resps(base + 1);
      check_order(base, 1, 3, 0, 0, 0);
      check("withdrawn_no_grant", 128'(gcnt[0]), 128'(g0));

      // Hung multiplier trips the sticky watchdog; counter saturates.
      base = resp_log.size();
      stall_mul = 1'b1;
      issue(2, 64'd6, 64'd7, 128'd42);
      repeat (80) @(posedge clk);
      #1;
      check("wd_err", 128'(err), 128'd1);
      check("wd_busy", 128'(busy), 128'd1);
      check("wd_no_rsp", 128'(bus.rsp_valid), 128'd0);
      stall_mul = 1'b0;
      wait_resps(base + 1);
      check_order(base, 1, 2, 0, 0, 0);
      check("wd_sticky", 128'(err), 128'd1);
      check("cnt_saturate", 128'(last_cycles), 128'd127);

      // Reset in the middle of an op drops it.
      issue(3, 64'd11, 64'd13, 128'd143);
      repeat (20) @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      check("midrst_busy", 128'(busy), 128'd0);
      check("midrst_rsp_valid", 128'(bus.rsp_valid), 128'd0);
      check("midrst_err", 128'(err), 128'd0);
      check("midrst_last_cycles", 128'(last_cycles), 128'd0);
      sb.delete();
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
      base = resp_log.size();
      issue(1, 64'd100, 64'd200, 128'd20000);
      wait_resps(base + 1);
      check_order(base, 1, 1, 0, 0, 0);
      check("post_rst_err", 128'(err), 128'd0);
      check("post_rst_latency", 128'(last_cycles <= 7'd65 && last_cycles >= 7'd1), 128'd1);

      repeat (5) @(posedge clk);
      check("sb_drained", 128'(sb.size()), 128'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
